// File: rtl/downstream_req_n_data_if.sv
// Signal bundle between the downstream read engine (master) and its channel arbiter,
// aligner and Dini FIFO neighbours (slave).
interface downstream_req_n_data_if;
    logic        channel_sel;
    logic        channel_req;
    logic [31:0] channel_saddr;
    logic [31:0] channel_daddr;
    logic [15:0] channel_length;
    logic [3:0]  channel_tag;
    logic        channel_busy;
    logic        channel_done;
    logic        channel_err;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] byte_length;
    logic        busif_start;
    logic [63:0] busif_data;
    logic        busif_data_en;
    logic        tohost_almost_full;
    logic [63:0] tohost_data;
    logic [7:0]  tohost_ctrl;
    logic        tohost_valid;
    logic [63:0] fromhost_data;
    logic [7:0]  fromhost_ctrl;
    logic        fromhost_valid;
    logic        fromhost_ready;

    modport master (
        input  channel_sel, channel_req, channel_saddr, channel_daddr, channel_length,
               channel_tag, tohost_almost_full, fromhost_data, fromhost_ctrl, fromhost_valid,
        output channel_busy, channel_done, channel_err, src_addr, dst_addr, byte_length,
               busif_start, busif_data, busif_data_en, tohost_data, tohost_ctrl, tohost_valid,
               fromhost_ready
    );

    modport slave (
        output channel_sel, channel_req, channel_saddr, channel_daddr, channel_length,
               channel_tag, tohost_almost_full, fromhost_data, fromhost_ctrl, fromhost_valid,
        input  channel_busy, channel_done, channel_err, src_addr, dst_addr, byte_length,
               busif_start, busif_data, busif_data_en, tohost_data, tohost_ctrl, tohost_valid,
               fromhost_ready
    );
endinterface

// File: rtl/downstream_req_n_data.sv
// Host-to-device read engine: issues a two-qword read descriptor to the tohost FIFO,
// then forwards completion qwords from the fromhost FIFO to the aligner.
module downstream_req_n_data #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    downstream_req_n_data_if.master   bus
);
    localparam int unsigned         IDLE_W    = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_DESC0, S_DESC1, S_DATA, S_DONE} state_t;

    state_t            state, state_nx;
    logic [31:0]       src_q, dst_q;
    logic [15:0]       len_q;
    logic [3:0]        tag_q;
    logic [16:0]       count_q;
    logic [IDLE_W-1:0] idle_q;
    logic              err_q, err_nx;
    logic              start_q;
    logic [63:0]       th_data_q;
    logic [7:0]        th_ctrl_q;
    logic              th_valid_q;
    logic [63:0]       bd_q;
    logic              bd_en_q;

    logic              accept, beat, fwd, is_last, is_early, is_timeout;
    logic [16:0]       ndw, nqw;
    logic [1:0]        end_off;
    logic [3:0]        first_be, last_be, fbe, lbe;
    logic [63:0]       word0, word1;
    logic              unused_bits;

    assign accept     = (state == S_IDLE) & bus.channel_sel & bus.channel_req;
    assign beat       = (state == S_DATA) & bus.fromhost_valid;
    assign fwd        = beat & ~bus.fromhost_ctrl[4];
    assign is_last    = fwd & (count_q == 17'd1);
    assign is_early   = fwd & bus.fromhost_ctrl[3] & (count_q != 17'd1);
    assign is_timeout = (state == S_DATA) & ~beat & (idle_q == IDLE_LAST);

    assign ndw     = (17'(len_q) + 17'(src_q[1:0]) + 17'd3) >> 2;
    assign nqw     = (17'(len_q) + 17'(src_q[2:0]) + 17'd7) >> 3;
    assign end_off = src_q[1:0] + len_q[1:0];

    always_comb begin
        first_be = 4'b1111;
        last_be  = 4'b1111;
        case (src_q[1:0])
            2'd1:    first_be = 4'b1110;
            2'd2:    first_be = 4'b1100;
            2'd3:    first_be = 4'b1000;
            default: first_be = 4'b1111;
        endcase
        case (end_off)
            2'd1:    last_be = 4'b0001;
            2'd2:    last_be = 4'b0011;
            2'd3:    last_be = 4'b0111;
            default: last_be = 4'b1111;
        endcase
        fbe = first_be;
        lbe = last_be;
        // a single-dword transfer carries the same mask in both fields
        if (ndw == 17'd1) begin
            fbe = first_be & last_be;
            lbe = first_be & last_be;
        end
    end

    assign word0 = {24'd0, tag_q, 4'd0, 1'b1, 1'b0, 3'd0, 1'b1, 2'd0, fbe, lbe, ndw[15:0]};
    assign word1 = {32'd0, src_q[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        err_nx   = err_q;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    err_nx   = 1'b0;
                    state_nx = (bus.channel_length == 16'd0) ? S_DONE : S_DESC0;
                end
            end
            S_DESC0: if (!bus.tohost_almost_full) state_nx = S_DESC1;
            S_DESC1: state_nx = S_DATA;
            S_DATA: begin
                if (is_last) begin
                    state_nx = S_DONE;
                    err_nx   = ~bus.fromhost_ctrl[3];
                end else if (is_early || is_timeout) begin
                    state_nx = S_DONE;
                    err_nx   = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            tag_q      <= '0;
            count_q    <= '0;
            idle_q     <= '0;
            start_q    <= 1'b0;
            th_data_q  <= '0;
            th_ctrl_q  <= '0;
            th_valid_q <= 1'b0;
            bd_q       <= '0;
            bd_en_q    <= 1'b0;
        end else begin
            th_valid_q <= 1'b0;
            bd_en_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        src_q <= bus.channel_saddr;
                        dst_q <= bus.channel_daddr;
                        len_q <= bus.channel_length;
                        tag_q <= bus.channel_tag;
                    end
                end
                S_DESC0: begin
                    if (!bus.tohost_almost_full) begin
                        th_valid_q <= 1'b1;
                        th_data_q  <= word0;
                        th_ctrl_q  <= 8'h17;
                        start_q    <= 1'b1;
                    end
                end
                S_DESC1: begin
                    th_valid_q <= 1'b1;
                    th_data_q  <= word1;
                    th_ctrl_q  <= 8'h17;
                    count_q    <= nqw;
                    idle_q     <= '0;
                end
                S_DATA: begin
                    idle_q <= beat ? '0 : idle_q + 1'b1;
                    if (fwd) begin
                        bd_q    <= bus.fromhost_data;
                        bd_en_q <= 1'b1;
                        count_q <= count_q - 17'd1;
                    end
                end
                S_DONE:  start_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.channel_busy   = (state != S_IDLE);
    assign bus.channel_done   = (state == S_DONE);
    assign bus.channel_err    = (state == S_DONE) & err_q;
    assign bus.src_addr       = src_q;
    assign bus.dst_addr       = dst_q;
    assign bus.byte_length    = len_q;
    assign bus.busif_start    = start_q;
    assign bus.busif_data     = bd_q;
    assign bus.busif_data_en  = bd_en_q;
    assign bus.tohost_data    = th_data_q;
    assign bus.tohost_ctrl    = th_ctrl_q;
    assign bus.tohost_valid   = th_valid_q;
    assign bus.fromhost_ready = (state == S_DATA);

    assign unused_bits = ^{ndw[16], bus.fromhost_ctrl[7:5], bus.fromhost_ctrl[2:0]};
endmodule

// File: tb/tb_downstream_req_n_data.sv
// Randomised bench for downstream_req_n_data: a transaction-level model predicts descriptor
// words, forwarded qwords and completion status, compared against the DUT every cycle.
module tb_downstream_req_n_data;
    localparam int unsigned TO = 40;

    typedef struct { int t; logic [63:0] d; } ev_t;
    typedef struct { logic [63:0] d; logic [7:0] c; } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    downstream_req_n_data_if bus_if ();
    downstream_req_n_data #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int          n_chk = 0, n_fail = 0, cyc = 0;
    ev_t         th_q[$], bi_q[$];
    beat_t       fh_q[$];
    logic [63:0] th_log[$];
    int          en_cnt = 0, done_cyc = 0, w1_cyc = 0;
    bit          rand_af = 1'b0, af_force = 1'b0;

    bit          m_busy = 0, m_wait = 0, m_start = 0, m_data = 0, m_err = 0;
    int          data_start = -1, done_at = -1, remaining = 0, idle = 0;
    logic [31:0] m_src = '0, m_dst = '0;
    logic [15:0] m_len = '0;
    logic [3:0]  m_tag = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int f_nqw(input logic [31:0] sa, input logic [15:0] len);
        return (int'(len) + int'(sa[2:0]) + 7) / 8;
    endfunction

    // descriptor word0 from byte offsets: mask out leading/trailing bytes of the dword span
    function automatic logic [63:0] f_word0(input logic [31:0] sa, input logic [15:0] len,
                                            input logic [3:0] tag);
        int o, e, ndw;
        logic [3:0] fbe, lbe;
        o   = int'(sa[1:0]);
        e   = (o + int'(len)) % 4;
        ndw = (int'(len) + o + 3) / 4;
        fbe = 4'((15 << o) & 15);
        lbe = (e == 0) ? 4'hF : 4'((1 << e) - 1);
        if (ndw == 1) begin
            fbe = fbe & lbe;
            lbe = fbe;
        end
        return {24'd0, tag, 4'd0,
                32'h8400_0000 | (32'(fbe) << 20) | (32'(lbe) << 16) | (32'(ndw) & 32'hFFFF)};
    endfunction

    // compare process: check this cycle against the model, then advance the model
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_flags", {bus_if.channel_busy, bus_if.channel_done, bus_if.channel_err,
                                  bus_if.fromhost_ready, bus_if.tohost_valid, bus_if.busif_start,
                                  bus_if.busif_data_en}, '0);
                chk("rst_tohost_data", bus_if.tohost_data, '0);
                chk("rst_tohost_ctrl", bus_if.tohost_ctrl, '0);
                chk("rst_busif_data", bus_if.busif_data, '0);
                chk("rst_latched", {bus_if.src_addr, bus_if.dst_addr}, '0);
                chk("rst_length", bus_if.byte_length, '0);
                m_busy = 0; m_wait = 0; m_start = 0; m_data = 0;
                data_start = -1; done_at = -1;
                th_q.delete();
                bi_q.delete();
            end else begin
                chk("channel_busy", bus_if.channel_busy, m_busy);
                chk("fromhost_ready", bus_if.fromhost_ready, m_data);
                chk("busif_start", bus_if.busif_start, m_start);
                if (th_q.size() != 0 && th_q[0].t == cyc) begin
                    chk("tohost_valid", bus_if.tohost_valid, 1);
                    chk("tohost_data", bus_if.tohost_data, th_q[0].d);
                    chk("tohost_ctrl", bus_if.tohost_ctrl, 8'h17);
                    th_q.delete(0);
                end else begin
                    chk("tohost_valid", bus_if.tohost_valid, 0);
                end
                if (bus_if.tohost_valid) th_log.push_back(bus_if.tohost_data);
                if (bi_q.size() != 0 && bi_q[0].t == cyc) begin
                    chk("busif_data_en", bus_if.busif_data_en, 1);
                    chk("busif_data", bus_if.busif_data, bi_q[0].d);
                    bi_q.delete(0);
                end else begin
                    chk("busif_data_en", bus_if.busif_data_en, 0);
                end
                if (bus_if.busif_data_en) en_cnt++;
                chk("channel_done", bus_if.channel_done, done_at == cyc);
                chk("channel_err", bus_if.channel_err, (done_at == cyc) && m_err);
                if (bus_if.channel_done) done_cyc = cyc;
                if (m_busy) begin
                    chk("src_addr", bus_if.src_addr, m_src);
                    chk("dst_addr", bus_if.dst_addr, m_dst);
                    chk("byte_length", bus_if.byte_length, m_len);
                end

                if (done_at == cyc) begin
                    m_busy = 0; m_start = 0; done_at = -1;
                end else if (!m_busy) begin
                    if (bus_if.channel_sel && bus_if.channel_req) begin
                        m_src = bus_if.channel_saddr;
                        m_dst = bus_if.channel_daddr;
                        m_len = bus_if.channel_length;
                        m_tag = bus_if.channel_tag;
                        m_busy = 1;
                        if (m_len == 0) begin
                            done_at = cyc + 1;
                            m_err = 0;
                        end else begin
                            m_wait = 1;
                        end
                    end
                end else if (m_wait) begin
                    if (!bus_if.tohost_almost_full) begin
                        ev.t = cyc + 1; ev.d = f_word0(m_src, m_len, m_tag); th_q.push_back(ev);
                        ev.t = cyc + 2; ev.d = {32'd0, m_src[31:2], 2'b00}; th_q.push_back(ev);
                        m_wait = 0;
                        m_start = 1;
                        data_start = cyc + 2;
                    end
                end else if (m_data) begin
                    if (bus_if.fromhost_valid) begin
                        idle = 0;
                        if (!bus_if.fromhost_ctrl[4]) begin
                            ev.t = cyc + 1; ev.d = bus_if.fromhost_data; bi_q.push_back(ev);
                            remaining--;
                            if (remaining == 0) begin
                                done_at = cyc + 1; m_err = !bus_if.fromhost_ctrl[3]; m_data = 0;
                            end else if (bus_if.fromhost_ctrl[3]) begin
                                done_at = cyc + 1; m_err = 1; m_data = 0;
                            end
                        end
                    end else begin
                        idle++;
                        if (idle >= int'(TO)) begin
                            done_at = cyc + 1; m_err = 1; m_data = 0;
                        end
                    end
                end
                if (data_start == cyc + 1) begin
                    m_data = 1;
                    remaining = f_nqw(m_src, m_len);
                    idle = 0;
                    data_start = -1;
                    w1_cyc = cyc + 1;
                end
            end
        end
    end

    // fromhost FIFO head: present queued beats with random gaps, pop on acceptance
    initial begin
        bus_if.fromhost_valid = 1'b0;
        bus_if.fromhost_data  = '0;
        bus_if.fromhost_ctrl  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (fh_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                bus_if.fromhost_valid = 1'b1;
                bus_if.fromhost_data  = fh_q[0].d;
                bus_if.fromhost_ctrl  = fh_q[0].c;
            end else begin
                bus_if.fromhost_valid = 1'b0;
            end
            @(negedge clk);
            if (bus_if.fromhost_valid && bus_if.fromhost_ready && fh_q.size() != 0) fh_q.delete(0);
        end
    end

    initial begin
        bus_if.tohost_almost_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.tohost_almost_full = af_force | (rand_af && $urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic mk_beats(input int n, input int err_at, input int n_disc);
        beat_t b;
        fh_q.delete();
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom};
            b.c = 8'($urandom) & 8'hE7;
            if (i == n - 1 || i == err_at) b.c[3] = 1'b1;
            fh_q.push_back(b);
        end
        for (int j = 0; j < n_disc; j++) begin
            b.d = {$urandom, $urandom};
            b.c = (8'($urandom) & 8'hE7) | 8'h10;
            fh_q.insert($urandom_range(0, fh_q.size()), b);
        end
    endtask

    task automatic issue(input logic [31:0] sa, input logic [31:0] da, input logic [15:0] len,
                         input logic [3:0] tag);
        @(posedge clk);
        #1;
        bus_if.channel_sel    = 1'b1;
        bus_if.channel_req    = 1'b1;
        bus_if.channel_saddr  = sa;
        bus_if.channel_daddr  = da;
        bus_if.channel_length = len;
        bus_if.channel_tag    = tag;
        @(posedge clk);
        #1;
        bus_if.channel_req = 1'b0;
        bus_if.channel_sel = 1'($urandom_range(0, 1));
    endtask

    task automatic stray();
        @(posedge clk);
        #1;
        bus_if.channel_sel    = 1'b1;
        bus_if.channel_req    = 1'b1;
        bus_if.channel_saddr  = $urandom;
        bus_if.channel_daddr  = $urandom;
        bus_if.channel_length = 16'($urandom_range(1, 200));
        @(posedge clk);
        #1;
        bus_if.channel_req = 1'b0;
    endtask

    task automatic wait_done(input int lim, output logic err);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_if.channel_done && k < lim);
        chk("done_within_budget", bus_if.channel_done, 1);
        err = bus_if.channel_err;
        repeat (2) @(negedge clk);
        fh_q.delete();
    endtask

    initial begin
        int          base, e0, n, ea;
        logic        err;
        logic [31:0] sa;
        logic [15:0] len;

        bus_if.channel_sel    = 1'b0;
        bus_if.channel_req    = 1'b0;
        bus_if.channel_saddr  = '0;
        bus_if.channel_daddr  = '0;
        bus_if.channel_length = '0;
        bus_if.channel_tag    = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // aligned 64-byte read, 8 completion qwords
        base = th_log.size(); e0 = en_cnt;
        mk_beats(8, -1, 0);
        issue(32'h0000_1000, 32'hA000_0000, 16'd64, 4'd5);
        wait_done(300, err);
        chk("t1_desc_count", th_log.size() - base, 2);
        if (th_log.size() >= base + 2) begin
            chk("t1_word0", th_log[base], 64'h0000_0050_84FF_0010);
            chk("t1_word1", th_log[base + 1], 64'h0000_0000_0000_1000);
        end
        chk("t1_beats", en_cnt - e0, 8);
        chk("t1_err", err, 0);

        // straddles a dword boundary: two dwords, one qword
        base = th_log.size();
        mk_beats(1, -1, 0);
        issue(32'h0000_1003, 32'h0, 16'd2, 4'd3);
        wait_done(100, err);
        if (th_log.size() >= base + 1) chk("t2_word0", th_log[base], 64'h0000_0030_8481_0002);
        chk("t2_err", err, 0);

        // single dword
        base = th_log.size();
        mk_beats(1, -1, 0);
        issue(32'h0000_1001, 32'h0, 16'd2, 4'd9);
        wait_done(100, err);
        if (th_log.size() >= base + 1) chk("t3_word0", th_log[base], 64'h0000_0090_8466_0001);
        chk("t3_err", err, 0);

        // tohost FIFO backpressure holds the descriptor
        af_force = 1'b1;
        repeat (2) @(posedge clk);
        base = th_log.size();
        mk_beats(1, -1, 0);
        issue(32'h0000_2000, 32'h0, 16'd8, 4'd1);
        repeat (10) @(negedge clk);
        chk("t4_no_desc_while_full", th_log.size() - base, 0);
        chk("t4_busy_while_full", bus_if.channel_busy, 1);
        af_force = 1'b0;
        wait_done(100, err);
        chk("t4_desc_after_release", th_log.size() - base, 2);
        chk("t4_err", err, 0);

        // early last flag on beat 2 of 4
        e0 = en_cnt;
        mk_beats(4, 1, 0);
        issue(32'h0, 32'h0, 16'd32, 4'd2);
        wait_done(100, err);
        chk("t5_beats", en_cnt - e0, 2);
        chk("t5_err", err, 1);

        // no completions at all
        mk_beats(0, -1, 0);
        issue(32'h0, 32'h0, 16'd32, 4'd2);
        wait_done(TO + 50, err);
        chk("t6_err", err, 1);
        chk("t6_timeout_cycles", done_cyc - w1_cyc, TO);

        // interleaved descriptor-type beats are dropped
        e0 = en_cnt;
        mk_beats(2, -1, 3);
        issue(32'h0000_0040, 32'h0, 16'd16, 4'd7);
        wait_done(100, err);
        chk("t7_beats", en_cnt - e0, 2);
        chk("t7_err", err, 0);

        // zero-length request
        base = th_log.size();
        mk_beats(0, -1, 0);
        issue(32'h0000_3000, 32'h0, 16'd0, 4'd4);
        wait_done(20, err);
        chk("t8_no_desc", th_log.size() - base, 0);
        chk("t8_err", err, 0);

        // reset in the middle of data transfer
        mk_beats(8, -1, 0);
        issue(32'h0000_4000, 32'h0, 16'd64, 4'd6);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t9_busy_in_rst", bus_if.channel_busy, 0);
        chk("t9_en_in_rst", bus_if.busif_data_en, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        fh_q.delete();
        repeat (3) @(negedge clk);

        // randomised requests with random backpressure, discards, early ends and stray requests
        rand_af = 1'b1;
        for (int r = 0; r < 40; r++) begin
            sa  = $urandom;
            len = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 100));
            n   = (len == 0) ? 0 : f_nqw(sa, len);
            ea  = (n > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 2)) : -1;
            mk_beats(n, ea, $urandom_range(0, 2));
            issue(sa, $urandom, len, 4'($urandom));
            if (len != 0 && $urandom_range(0, 1) == 1) stray();
            wait_done(600, err);
            chk("rnd_drained", th_q.size() + bi_q.size(), 0);
        end
        rand_af = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
